// File: rtl/axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rr_arbiter
//   N-master arbiter for the shared AXI address/data path. Grants one master
//   at a time and keeps that grant locked until the owner's finish pulse or
//   until the hold watchdog expires. Arbitration is round-robin (MODE 0) or
//   fixed priority with the lowest index winning (MODE 1).
//
// Ports
//   ACLK        clock, all state updates on the rising edge
//   ARESET      synchronous active-high reset
//   req         per-master level-sensitive request
//   finish      per-master one-cycle pulse on the owner's last handshake
//   grant       one-hot grant, all zero when idle (registered)
//   grant_idx   binary owner index, holds its last value when idle (registered)
//   grant_valid high while a grant is held (registered)
//   timeout     one-cycle pulse after a watchdog-forced release (registered)
// ---------------------------------------------------------------------------
module axi_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = $clog2(N_MASTERS),
  parameter int MODE      = 0,
  parameter int MAX_HOLD  = 256
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] finish,
  output logic [N_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid,
  output logic                 timeout
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // A disabled watchdog still keeps a 1-bit counter so no zero-width vector exists.
  localparam bit WD_EN = (MAX_HOLD > 0);
  localparam int CNT_W = WD_EN ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST_I = WD_EN ? (MAX_HOLD - 1) : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Pointer starts at the last master so master 0 wins the first round.
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_MASTERS - 1);

  logic [0:0]           state_q,       state_d;
  logic [IDX_W-1:0]     ptr_q,         ptr_d;
  logic [CNT_W-1:0]     hold_cnt_q,    hold_cnt_d;
  logic [N_MASTERS-1:0] grant_q,       grant_d;
  logic [IDX_W-1:0]     grant_idx_q,   grant_idx_d;
  logic                 grant_valid_q, grant_valid_d;
  logic                 timeout_q,     timeout_d;

  logic [IDX_W-1:0]     cand_s;
  logic [IDX_W-1:0]     rr_idx_s;
  logic                 rr_found_s;
  logic [IDX_W-1:0]     fp_idx_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic                 any_req_s;
  logic                 owner_fin_s;
  logic                 wd_exp_s;

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

  // Round-robin search: first requester after ptr, wrapping modulo N_MASTERS.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = {IDX_W{1'b0}};
    cand_s     = {IDX_W{1'b0}};
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand_s = IDX_W'((int'(ptr_q) + i) % N_MASTERS);
      if (!rr_found_s && req[cand_s]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = cand_s;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Fixed priority: scanning downward leaves the lowest set index last.
  always_comb begin
    fp_idx_s = {IDX_W{1'b0}};
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (req[IDX_W'(i)]) begin
        fp_idx_s = IDX_W'(i);
      end else begin
        fp_idx_s = fp_idx_s;
      end
    end
  end

  // Winner selection and release conditions.
  always_comb begin
    any_req_s   = |req;
    owner_fin_s = finish[grant_idx_q];
    wd_exp_s    = WD_EN && (state_q == ST_LOCKED) && (hold_cnt_q == HOLD_LAST);
    if (MODE == 1) begin
      win_idx_s = fp_idx_s;
    end else begin
      win_idx_s = rr_idx_s;
    end
  end

  // Next-state logic: arbitration in IDLE, lock/release handling in LOCKED.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d            = ST_LOCKED;
          ptr_d              = win_idx_s;
          hold_cnt_d         = {CNT_W{1'b0}};
          grant_d            = {N_MASTERS{1'b0}};
          grant_d[win_idx_s] = 1'b1;
          grant_idx_d        = win_idx_s;
          grant_valid_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (owner_fin_s || wd_exp_s) begin
          // A finish coinciding with expiry counts as a normal finish.
          timeout_d = wd_exp_s && !owner_fin_s;
          if (any_req_s) begin
            state_d            = ST_LOCKED;
            ptr_d              = win_idx_s;
            hold_cnt_d         = {CNT_W{1'b0}};
            grant_d            = {N_MASTERS{1'b0}};
            grant_d[win_idx_s] = 1'b1;
            grant_idx_d        = win_idx_s;
            grant_valid_d      = 1'b1;
          end else begin
            state_d       = ST_IDLE;
            grant_d       = {N_MASTERS{1'b0}};
            grant_valid_d = 1'b0;
          end
        end else begin
          // Counter saturates so a disabled watchdog never wraps.
          if (hold_cnt_q != CNT_MAX) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_d       = {N_MASTERS{1'b0}};
        grant_valid_d = 1'b0;
        hold_cnt_d    = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= ST_IDLE;
      ptr_q         <= PTR_RST;
      hold_cnt_q    <= {CNT_W{1'b0}};
      grant_q       <= {N_MASTERS{1'b0}};
      grant_idx_q   <= {IDX_W{1'b0}};
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rr_arbiter
//   Two 4-master instances: dut0 round-robin with an 8-cycle watchdog, dut1
//   fixed priority with the watchdog disabled. Each stimulus step drives the
//   inputs on the falling edge and queues the hand-computed outputs expected
//   after the next rising edge; a separate monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_axi_rr_arbiter;

  logic       clk;
  logic       rst0, rst1;
  logic [3:0] req0, fin0, req1, fin1;
  logic [3:0] g0, g1;
  logic [1:0] i0, i1;
  logic       v0, v1, t0, t1;

  typedef struct {
    int         dut;
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
    logic       t;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  axi_rr_arbiter #(.N_MASTERS(4), .MODE(0), .MAX_HOLD(8)) dut0 (
    .ACLK(clk), .ARESET(rst0), .req(req0), .finish(fin0),
    .grant(g0), .grant_idx(i0), .grant_valid(v0), .timeout(t0)
  );

  axi_rr_arbiter #(.N_MASTERS(4), .MODE(1), .MAX_HOLD(0)) dut1 (
    .ACLK(clk), .ARESET(rst1), .req(req1), .finish(fin1),
    .grant(g1), .grant_idx(i1), .grant_valid(v1), .timeout(t1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input int d, input logic rst, input logic [3:0] r, input logic [3:0] f,
                      input logic [3:0] eg, input logic [1:0] ei, input logic ev, input logic et,
                      input string nm);
    exp_t e;
    @(negedge clk);
    if (d == 0) begin
      rst0 = rst; req0 = r; fin0 = f;
    end else begin
      rst1 = rst; req1 = r; fin1 = f;
    end
    e.dut = d; e.g = eg; e.idx = ei; e.v = ev; e.t = et; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    logic [3:0] ag;
    logic [1:0] ai;
    logic av, at;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          ag = g0; ai = i0; av = v0; at = t0;
        end else begin
          ag = g1; ai = i1; av = v1; at = t1;
        end
        tests_run++;
        if (ag !== e.g || ai !== e.idx || av !== e.v || at !== e.t) begin
          tests_failed++;
          $display("FAIL %s (dut%0d): got grant=%b idx=%0d valid=%b timeout=%b, expected grant=%b idx=%0d valid=%b timeout=%b",
                   e.nm, e.dut, ag, ai, av, at, e.g, e.idx, e.v, e.t);
        end
      end
    end
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    req0 = 4'b0000; fin0 = 4'b0000;
    req1 = 4'b0000; fin1 = 4'b0000;

    // ---------------- dut0: round-robin, MAX_HOLD = 8 ----------------
    step(0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_a");
    step(0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_b");
    step(0, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "first_grant");
    step(0, 1'b0, 4'b1111, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0, "rr_1");
    step(0, 1'b0, 4'b1111, 4'b0010, 4'b0100, 2'd2, 1'b1, 1'b0, "rr_2");
    step(0, 1'b0, 4'b1111, 4'b0100, 4'b1000, 2'd3, 1'b1, 1'b0, "rr_3");
    step(0, 1'b0, 4'b1111, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_wrap");
    step(0, 1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_hold");
    // Lock behaviour: owner drops req, stray finish from a non-owner.
    step(0, 1'b0, 4'b0010, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0, "to_owner1");
    step(0, 1'b0, 4'b0000, 4'b0100, 4'b0010, 2'd1, 1'b1, 1'b0, "stray_finish");
    step(0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0, "release_idle");
    step(0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "stay_idle");
    // Previous owner wins back only as the sole requester.
    step(0, 1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, "idle_grant1");
    step(0, 1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "sole_winback");
    step(0, 1'b0, 4'b0110, 4'b0010, 4'b0100, 2'd2, 1'b1, 1'b0, "no_winback");
    step(0, 1'b0, 4'b0110, 4'b0100, 4'b0010, 2'd1, 1'b1, 1'b0, "rr_wrap_1");
    step(0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0, "release_idle2");
    // Watchdog: master 0 granted at edge g, never finishes; released at g+8.
    step(0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "wd_grant0");
    for (int k = 1; k <= 7; k++)
      step(0, 1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "wd_hold");
    step(0, 1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1, "wd_expire");
    step(0, 1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "wd_pulse_end");
    for (int k = 2; k <= 7; k++)
      step(0, 1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0, "wd_hold2");
    // Finish on the expiry cycle is a normal finish: no timeout.
    step(0, 1'b0, 4'b0101, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0, "wd_fin_same");
    step(0, 1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "wd_fin_after");
    // Mid-transaction reset: pointer returns to N-1, so master 0 wins.
    step(0, 1'b0, 4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0, "pre_reset");
    step(0, 1'b1, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "mid_reset_a");
    step(0, 1'b1, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "mid_reset_b");
    step(0, 1'b0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0, "post_reset");
    step(0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, "post_release");

    // ---------------- dut1: fixed priority, watchdog off ----------------
    step(1, 1'b1, 4'b1010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "fp_reset");
    step(1, 1'b0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0, "fp_first");
    step(1, 1'b0, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "fp_again1");
    step(1, 1'b0, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "fp_again2");
    step(1, 1'b0, 4'b1000, 4'b0010, 4'b1000, 2'd3, 1'b1, 1'b0, "fp_master3");
    for (int k = 0; k < 20; k++)
      step(1, 1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0, "fp_no_watchdog");
    step(1, 1'b0, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0, "fp_release");

    // Let the monitor drain the last expectation.
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
